// File: rtl/uart_tx.sv
// UART transmitter: valid/ready word intake, start + LSB-first data + optional parity + 1/2 stop bits.
// Bit timing from a per-frame baud divider; optional CTS gating of new frames.
module uart_tx #(
  parameter int unsigned CLK_HZ    = 30000000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned USE_CTS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pin_cts,
  output logic                 pin_tx,
  input  logic                 valid,
  output logic                 ready,
  input  logic [DATA_BITS-1:0] data,
  output logic                 busy
);

  localparam int unsigned DIV   = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int unsigned DIV_W = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_param_err
    $error("uart_tx: illegal parameter set");
  end

  logic [2:0]           state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 cts_meta_q, cts_sync_q;
  logic                 cts_ok;
  logic                 accept;
  logic                 bit_end;

  assign cts_ok  = (USE_CTS != 0) ? !cts_sync_q : 1'b1;
  assign ready   = (state_q == S_IDLE) && cts_ok && !rst;
  assign accept  = valid && ready;
  assign bit_end = (div_q == '0);
  assign busy    = (state_q != S_IDLE);
  assign pin_tx  = tx_q;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    if (state_q == S_IDLE) begin
      if (accept) begin
        state_d = S_START;
        div_d   = DIV_W'(DIV - 1);
        bit_d   = '0;
        shift_d = data;
        par_d   = (PARITY == 1) ? ~^data : ^data;
      end
    end else if (!bit_end) begin
      div_d = div_q - DIV_W'(1);
    end else begin
      div_d = DIV_W'(DIV - 1);
      case (state_q)
        S_START: begin
          state_d = S_DATA;
          bit_d   = '0;
        end
        S_DATA: begin
          shift_d = shift_q >> 1;
          if (bit_q == 4'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
        S_PARITY: begin
          state_d = S_STOP;
          bit_d   = '0;
        end
        S_STOP: begin
          if (bit_q == 4'(STOP_BITS - 1)) begin
            state_d = S_IDLE;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          bit_d   = '0;
        end
      endcase
    end
  end

  // Line level is registered from the next state so the pin never glitches on state changes.
  always_comb begin
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      cts_meta_q <= 1'b1;
      cts_sync_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      cts_meta_q <= pin_cts;
      cts_sync_q <= cts_meta_q;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances (8N1 default, 7E2 and 7O2 at DIV=4, the last without CTS).
module tb_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       cts0, cts1, cts2;
  logic       tx0, tx1, tx2;
  logic       v0, v1, v2;
  logic       r0, r1, r2;
  logic       b0, b1, b2;
  logic [7:0] d0;
  logic [6:0] d1, d2;

  int passes = 0;
  int checks = 0;

  uart_tx u0 (
    .clk(clk), .rst(rst), .pin_cts(cts0), .pin_tx(tx0),
    .valid(v0), .ready(r0), .data(d0), .busy(b0)
  );

  uart_tx #(.CLK_HZ(16), .BAUD(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .USE_CTS(1)) u1 (
    .clk(clk), .rst(rst), .pin_cts(cts1), .pin_tx(tx1),
    .valid(v1), .ready(r1), .data(d1), .busy(b1)
  );

  uart_tx #(.CLK_HZ(16), .BAUD(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .USE_CTS(0)) u2 (
    .clk(clk), .rst(rst), .pin_cts(cts2), .pin_tx(tx2),
    .valid(v2), .ready(r2), .data(d2), .busy(b2)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic tx_of(input int k);
    case (k)
      0:       return tx0;
      1:       return tx1;
      default: return tx2;
    endcase
  endfunction

  function automatic logic rdy_of(input int k);
    case (k)
      0:       return r0;
      1:       return r1;
      default: return r2;
    endcase
  endfunction

  function automatic logic busy_of(input int k);
    case (k)
      0:       return b0;
      1:       return b1;
      default: return b2;
    endcase
  endfunction

  task automatic set_valid(input int k, input logic v, input logic [7:0] d);
    case (k)
      0: begin v0 = v; d0 = d; end
      1: begin v1 = v; d1 = d[6:0]; end
      default: begin v2 = v; d2 = d[6:0]; end
    endcase
  endtask

  task automatic chk_all(input string tag, input int k, input logic etx, input logic erdy, input logic ebusy);
    chk($sformatf("%s tx", tag), tx_of(k), etx);
    chk($sformatf("%s ready", tag), rdy_of(k), erdy);
    chk($sformatf("%s busy", tag), busy_of(k), ebusy);
  endtask

  // Caller sets valid/data at a negedge where ready is high; the next edge accepts.
  // bits holds the expected line levels, first bit on the line in bit 0.
  task automatic run_frame(input string tag, input int k, input int div, input int nb,
                           input logic [15:0] bits, input logic hold_valid,
                           input logic [7:0] next_data, input int cts_at);
    for (int i = 0; i < nb * div; i++) begin
      @(negedge clk);
      if (i == 0) set_valid(k, hold_valid, next_data);
      if (i == cts_at) cts0 = 1'b1;
      chk_all($sformatf("%s bit%0d cyc%0d", tag, i / div, i % div), k, bits[i / div], 1'b0, 1'b1);
    end
  endtask

  initial begin
    rst = 1'b1;
    cts0 = 1'b0; cts1 = 1'b0; cts2 = 1'b1;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    d0 = '0; d1 = '0; d2 = '0;

    repeat (3) @(negedge clk);
    chk_all("reset u0", 0, 1'b1, 1'b0, 1'b0);
    chk_all("reset u1", 1, 1'b1, 1'b0, 1'b0);
    chk_all("reset u2", 2, 1'b1, 1'b0, 1'b0);

    rst = 1'b0;
    #1;
    chk("t5 ready at release u2", r2, 1'b1);
    chk("ready at release u0", r0, 1'b0);
    @(negedge clk);
    chk("cts sync edge1 u0", r0, 1'b0);
    chk("cts sync edge1 u1", r1, 1'b0);
    @(negedge clk);
    chk("cts sync edge2 u0", r0, 1'b1);
    chk("cts sync edge2 u1", r1, 1'b1);

    // 1: 8N1 0xA5 at DIV=260
    set_valid(0, 1'b1, 8'hA5);
    run_frame("t1", 0, 260, 10, {6'b0, 1'b1, 8'hA5, 1'b0}, 1'b0, 8'h00, -1);
    @(negedge clk);
    chk_all("t1 idle", 0, 1'b1, 1'b1, 1'b0);

    // 2: 7E2 0x07 -> parity 1
    set_valid(1, 1'b1, 8'h07);
    run_frame("t2", 1, 4, 11, {5'b0, 2'b11, 1'b1, 7'h07, 1'b0}, 1'b0, 8'h00, -1);
    @(negedge clk);
    chk_all("t2 idle", 1, 1'b1, 1'b1, 1'b0);

    // 5: 7O2 0x07 -> parity 0, CTS ignored while pin_cts = 1
    set_valid(2, 1'b1, 8'h07);
    run_frame("t5", 2, 4, 11, {5'b0, 2'b11, 1'b0, 7'h07, 1'b0}, 1'b0, 8'h00, -1);
    @(negedge clk);
    chk_all("t5 idle", 2, 1'b1, 1'b1, 1'b0);

    // 3: back-to-back 0x00 then 0x7F with valid held high
    set_valid(1, 1'b1, 8'h00);
    run_frame("t3a", 1, 4, 11, {5'b0, 2'b11, 1'b0, 7'h00, 1'b0}, 1'b1, 8'h7F, -1);
    @(negedge clk);
    chk_all("t3 gap", 1, 1'b1, 1'b1, 1'b0);
    run_frame("t3b", 1, 4, 11, {5'b0, 2'b11, 1'b1, 7'h7F, 1'b0}, 1'b0, 8'h00, -1);
    @(negedge clk);
    chk_all("t3 idle", 1, 1'b1, 1'b1, 1'b0);

    // 4: CTS gating
    cts0 = 1'b1;
    @(negedge clk);
    chk("t4 cts off edge1 ready", r0, 1'b1);
    @(negedge clk);
    chk("t4 cts off edge2 ready", r0, 1'b0);
    set_valid(0, 1'b1, 8'h5A);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk_all($sformatf("t4 blocked cyc%0d", i), 0, 1'b1, 1'b0, 1'b0);
    end
    cts0 = 1'b0;
    @(negedge clk);
    chk_all("t4 cts on edge1", 0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk_all("t4 cts on edge2", 0, 1'b1, 1'b1, 1'b0);
    run_frame("t4", 0, 260, 10, {6'b0, 1'b1, 8'h5A, 1'b0}, 1'b0, 8'h00, 1000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_all($sformatf("t4 after cyc%0d", i), 0, 1'b1, 1'b0, 1'b0);
    end

    // 6: async reset during DATA, then a clean 0x3C frame
    cts0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t6 ready before", r0, 1'b1);
    set_valid(0, 1'b1, 8'h3C);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (i == 0) set_valid(0, 1'b0, 8'h00);
    end
    chk("t6 mid-data tx", tx0, 1'b0);
    chk("t6 mid-data busy", b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk_all("t6 async reset", 0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_all("t6 release edge1", 0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk_all("t6 release edge2", 0, 1'b1, 1'b1, 1'b0);
    set_valid(0, 1'b1, 8'h3C);
    run_frame("t6", 0, 260, 10, {6'b0, 1'b1, 8'h3C, 1'b0}, 1'b0, 8'h00, -1);
    @(negedge clk);
    chk_all("t6 idle", 0, 1'b1, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
